// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: shared state encoding and counter sizing for the deserializer
package sipo_deserializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_word_hold.sv
// sipo_word_hold: one-word valid/ready holding register with overflow detection
module sipo_word_hold #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  dout_ready,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ovf_err
);
  logic hs, take;
  assign hs   = dout_valid && dout_ready;
  assign take = load && (!dout_valid || dout_ready);
  // load a completed word when the slot is free or being emptied; otherwise flag the drop
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      dout       <= take ? din : dout;
      dout_valid <= take ? 1'b1 : hs ? 1'b0 : dout_valid;
      ovf_err    <= (load && !take) ? 1'b1 : err_clr ? 1'b0 : ovf_err;
    end
  end
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: frames LSB-first serial bits into words presented on a valid/ready port
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sin,
  input  logic                  sin_valid,
  input  logic                  sin_first,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  abort_err,
  output logic                  ovf_err,
  input  logic                  err_clr
);
  localparam int CW = cnt_width(DATA_WIDTH);
  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q, nxt;
  logic [CW-1:0]         bit_cnt;
  logic                  data_bit, done;
  assign data_bit = sin_valid && !sin_first && state == SHIFT;
  assign nxt      = {sin, shift_q[DATA_WIDTH-1:1]};
  assign done     = data_bit && bit_cnt == CW'(DATA_WIDTH - 1);
  assign busy     = state == SHIFT;
  // framing FSM: sin_first always restarts a word, data bits shift in until the word completes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      abort_err <= 1'b0;
    end else begin
      if (sin_valid && sin_first) begin
        state   <= SHIFT;
        shift_q <= {sin, {(DATA_WIDTH-1){1'b0}}};
        bit_cnt <= CW'(1);
      end else if (data_bit) begin
        state   <= done ? IDLE : SHIFT;
        shift_q <= nxt;
        bit_cnt <= done ? '0 : bit_cnt + CW'(1);
      end
      abort_err <= (sin_valid && sin_first && state == SHIFT) ? 1'b1 : err_clr ? 1'b0 : abort_err;
    end
  end
  sipo_word_hold #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk        (clk),
    .resetn     (resetn),
    .load       (done),
    .din        (nxt),
    .dout_ready (dout_ready),
    .err_clr    (err_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovf_err    (ovf_err)
  );
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer: the receive end of the team's LSB-first parallel-in/serial-out shift-register link. It accepts one qualified bit per cycle and frames bits into DATA_WIDTH-bit words using a first-bit marker. Each completed word is presented on a valid/ready output port backed by a one-word holding register. It sits between the serial link and the word-level consumer, and reports framing aborts and overflow through sticky flags.

## Interface
- DATA_WIDTH, 16, word width in bits; must be ≥ 2
- clk  in  1  clock; all logic is rising-edge
- resetn  in  1  reset, synchronous, active-low
- sin  in  1  serial data bit; LSB of each word is sent first
- sin_valid  in  1  sin is sampled on this edge
- sin_first  in  1  qualified by sin_valid; this bit is bit 0 of a new word
- dout  out  DATA_WIDTH  completed word in the holding register
- dout_valid  out  1  holding register contains an unconsumed word
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready
- busy  out  1  a word is partially received (state SHIFT)
- abort_err  out  1  sticky; a word was aborted by sin_first
- ovf_err  out  1  sticky; a completed word was dropped
- err_clr  in  1  clears both sticky flags

## Operation
- State machine with two states:
  - IDLE: bits arriving with sin_valid && !sin_first are discarded.
  - IDLE → SHIFT on sin_valid && sin_first. The bit is captured as bit 0 and bit_cnt is set to 1.
  - SHIFT: on each sin_valid && !sin_first, shift_q becomes {sin, shift_q[W-1:1]} and bit_cnt increments.
  - sin_valid low means no shift and no count. Gaps of any length are legal.
- Word completion: the bit that brings bit_cnt to DATA_WIDTH completes the word.
  - The completed value is {sin, shift_q[W-1:1]}, so bit 0 is the first bit received.
  - State returns to IDLE and bit_cnt returns to 0.
- Holding register:
  - On completion, if the register is empty, or dout_valid && dout_ready on the same edge, the new word is loaded and dout_valid is 1 next cycle.
  - Otherwise the new word is dropped, dout keeps the old word, and ovf_err is set.
  - Handshake without a completion: dout_valid goes to 0 next cycle and dout holds its last value.
  - dout and dout_valid must not change while dout_valid && !dout_ready, except through reset.
- Resync:
  - sin_valid && sin_first while in SHIFT discards the partial word and sets abort_err.
  - The new bit becomes bit 0 with bit_cnt = 1, and state stays SHIFT.
  - A sin_first arriving on a bit that would otherwise complete a word is treated as an abort, not a completion.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr coincides with a set event on the same edge, the set wins.
- bit_cnt width is $clog2(DATA_WIDTH+1). It never exceeds DATA_WIDTH and never wraps.

## Timing
- All outputs are registered.
- Reset values: dout = 0, dout_valid = 0, busy = 0, abort_err = 0, ovf_err = 0, state = IDLE, bit_cnt = 0, shift_q = 0.
- Reset mid-word or with a word pending drops everything. The first sin_first after reset release starts a fresh word.
- Latency: the last bit is sampled at edge N, and dout/dout_valid are valid after edge N, i.e. in cycle N+1.
- Throughput: one word per DATA_WIDTH cycles sustained, with dout_ready held high and no bubbles.
- busy rises the cycle after the first bit and falls the cycle after completion.
- dout_valid has no combinational dependency on dout_ready.

## Structure
- Package sipo_deserializer_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a function returning the counter width for a given DATA_WIDTH.
- Sub-module sipo_word_hold:
  - one-word valid/ready holding register;
  - load/drop decision and ovf_err generation.
- Top level holds the FSM, shift register, bit counter and abort_err.

## Test plan
- W=16: send 0xA5C3 LSB-first with sin_first on bit 0 and dout_ready=1 → dout=0xA5C3, dout_valid high for exactly one cycle, one cycle after the 16th bit.
- Same word with random 0–3 cycle sin_valid gaps, plus stray bits in IDLE before sin_first → dout=0xA5C3, no errors.
- dout_ready=0: send 0x1111 then 0x2222 → dout stays 0x1111, ovf_err=1. Set dout_ready=1 → one handshake, then dout_valid=0.
- 0x1111 pending; 0x2222 completes on the same edge as the handshake → dout=0x2222 next cycle, ovf_err=0.
- Send 9 bits, then sin_first and 0xBEEF → abort_err=1, dout=0xBEEF. Assert err_clr → flag clears next cycle.
- resetn low after 8 bits of a word with a word pending → all outputs at reset values. Next framed 0x0F0F is received correctly.
